// File: rtl/recepcao_face_serial_pkg.sv
// Shared definitions for the face receiver: colour codes, FSM encodings and
// the ASCII-letter-to-pixel decoder.
package recepcao_face_serial_pkg;

  localparam logic [2:0] COR_BRANCO   = 3'd0;
  localparam logic [2:0] COR_AMARELO  = 3'd1;
  localparam logic [2:0] COR_VERMELHO = 3'd2;
  localparam logic [2:0] COR_LARANJA  = 3'd3;
  localparam logic [2:0] COR_AZUL     = 3'd4;
  localparam logic [2:0] COR_VERDE    = 3'd5;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_G  = 8'h47;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_Y  = 8'h59;
  localparam logic [7:0] ASCII_A_MIN = 8'h61;
  localparam logic [7:0] ASCII_Z_MIN = 8'h7A;

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    ESPERA     = 4'd2,
    DECODIFICA = 4'd3,
    ESCREVE    = 4'd4,
    PROXIMO    = 4'd5,
    FIM        = 4'd6
  } estado_t;

  typedef enum logic [1:0] {
    RX_OCIOSO,
    RX_INICIO,
    RX_DADOS,
    RX_PARADA
  } rx_estado_t;

  typedef struct packed {
    logic       valido;
    logic       ignorar;
    logic [2:0] codigo;
  } decod_t;

  function automatic decod_t decodifica(input logic [7:0] c);
    decod_t     r;
    logic [7:0] m;
    r = '0;
    m = c;
    if (c >= ASCII_A_MIN && c <= ASCII_Z_MIN) m = c - 8'h20;
    case (m)
      ASCII_W:            begin r.valido = 1'b1; r.codigo = COR_BRANCO;   end
      ASCII_Y:            begin r.valido = 1'b1; r.codigo = COR_AMARELO;  end
      ASCII_R:            begin r.valido = 1'b1; r.codigo = COR_VERMELHO; end
      ASCII_O:            begin r.valido = 1'b1; r.codigo = COR_LARANJA;  end
      ASCII_B:            begin r.valido = 1'b1; r.codigo = COR_AZUL;     end
      ASCII_G:            begin r.valido = 1'b1; r.codigo = COR_VERDE;    end
      ASCII_CR, ASCII_LF: r.ignorar = 1'b1;
      default:            r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/recepcao_face_serial_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, start-bit re-check at half period,
// mid-bit sampling, one-cycle dado_valido or erro_quadro per frame.
module rx_serial_8n1
  import recepcao_face_serial_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic       dado_valido,
  output logic [7:0] dado,
  output logic       erro_quadro
);

  localparam int PERIODO = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int MEIO    = PERIODO / 2;
  localparam int CW      = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam logic [CW-1:0] PERIODO_FIM = CW'(PERIODO - 1);
  localparam logic [CW-1:0] MEIO_FIM    = CW'(MEIO - 1);

  rx_estado_t    estado_q, estado_d;
  logic [1:0]    sinc_q, sinc_d;
  logic          ant_q, ant_d;
  logic [CW-1:0] cont_q, cont_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    desloc_q, desloc_d;
  logic          valido_q, valido_d;
  logic          erro_q, erro_d;
  logic          linha;

  assign linha = sinc_q[1];

  // NOTE: every signal gets its default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    estado_d = estado_q;
    sinc_d   = {sinc_q[0], entrada_serial};
    ant_d    = linha;
    cont_d   = cont_q;
    bit_d    = bit_q;
    desloc_d = desloc_q;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    case (estado_q)
      RX_OCIOSO: begin
        if (ant_q && !linha) begin
          estado_d = RX_INICIO;
          cont_d   = '0;
        end
      end
      RX_INICIO: begin
        if (cont_q == MEIO_FIM) begin
          cont_d   = '0;
          bit_d    = '0;
          estado_d = linha ? RX_OCIOSO : RX_DADOS;
        end else begin
          cont_d = cont_q + 1'b1;
        end
      end
      RX_DADOS: begin
        if (cont_q == PERIODO_FIM) begin
          cont_d   = '0;
          desloc_d = {linha, desloc_q[7:1]};
          if (bit_q == 3'd7) estado_d = RX_PARADA;
          else               bit_d    = bit_q + 3'd1;
        end else begin
          cont_d = cont_q + 1'b1;
        end
      end
      RX_PARADA: begin
        // Back to idle at mid stop bit so a directly following start edge is seen.
        if (cont_q == PERIODO_FIM) begin
          cont_d   = '0;
          estado_d = RX_OCIOSO;
          valido_d = linha;
          erro_d   = !linha;
        end else begin
          cont_d = cont_q + 1'b1;
        end
      end
      default: estado_d = RX_OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= RX_OCIOSO;
      sinc_q   <= 2'b11;
      ant_q    <= 1'b1;
      cont_q   <= '0;
      bit_q    <= '0;
      desloc_q <= '0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sinc_q   <= sinc_d;
      ant_q    <= ant_d;
      cont_q   <= cont_d;
      bit_q    <= bit_d;
      desloc_q <= desloc_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
    end
  end

  assign dado_valido = valido_q;
  assign dado        = desloc_q;
  assign erro_quadro = erro_q;

endmodule

// File: rtl/recepcao_face_serial.sv
// Receives one cube face as ASCII colour letters over UART and writes the
// decoded pixel codes row-major into the shared face memory.
module recepcao_face_serial
  import recepcao_face_serial_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int LINHAS   = 3,
  parameter int COLUNAS  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       entrada_serial,
  output logic       escreve,
  output logic [1:0] addr_linha,
  output logic [1:0] addr_coluna,
  output logic [2:0] dados_pixel,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado,
  output logic [7:0] db_dado_recebido
);

  localparam logic [1:0] ULT_LINHA  = 2'(LINHAS - 1);
  localparam logic [1:0] ULT_COLUNA = 2'(COLUNAS - 1);

  logic       rx_valido;
  logic       rx_erro_quadro;
  logic [7:0] rx_dado;

  rx_serial_8n1 #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_rx (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .dado_valido   (rx_valido),
    .dado          (rx_dado),
    .erro_quadro   (rx_erro_quadro)
  );

  estado_t    estado_q, estado_d;
  logic [1:0] linha_q, linha_d;
  logic [1:0] coluna_q, coluna_d;
  logic       erro_q, erro_d;
  logic [7:0] byte_q, byte_d;
  logic [2:0] codigo_q, codigo_d;
  logic [7:0] db_dado_q, db_dado_d;
  decod_t     dec;

  assign dec = decodifica(byte_q);

  always_comb begin
    estado_d  = estado_q;
    linha_d   = linha_q;
    coluna_d  = coluna_q;
    erro_d    = erro_q;
    byte_d    = byte_q;
    codigo_d  = codigo_q;
    db_dado_d = rx_valido ? rx_dado : db_dado_q;
    case (estado_q)
      INICIAL: if (iniciar) estado_d = PREPARA;
      PREPARA: begin
        linha_d  = '0;
        coluna_d = '0;
        erro_d   = 1'b0;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (rx_valido) begin
          byte_d   = rx_dado;
          estado_d = DECODIFICA;
        end
      end
      DECODIFICA: begin
        if (dec.valido) begin
          codigo_d = dec.codigo;
          estado_d = ESCREVE;
        end else begin
          if (!dec.ignorar) erro_d = 1'b1;
          estado_d = ESPERA;
        end
      end
      ESCREVE: estado_d = PROXIMO;
      PROXIMO: begin
        if (linha_q == ULT_LINHA && coluna_q == ULT_COLUNA) begin
          estado_d = FIM;
        end else begin
          estado_d = ESPERA;
          if (coluna_q == ULT_COLUNA) begin
            coluna_d = '0;
            linha_d  = linha_q + 2'd1;
          end else begin
            coluna_d = coluna_q + 2'd1;
          end
        end
      end
      FIM:     if (iniciar) estado_d = PREPARA;
      default: estado_d = INICIAL;
    endcase
    // Framing errors only count while a face is being collected.
    if (rx_erro_quadro &&
        (estado_q == ESPERA || estado_q == DECODIFICA ||
         estado_q == ESCREVE || estado_q == PROXIMO))
      erro_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      linha_q   <= '0;
      coluna_q  <= '0;
      erro_q    <= 1'b0;
      byte_q    <= '0;
      codigo_q  <= '0;
      db_dado_q <= '0;
    end else begin
      estado_q  <= estado_d;
      linha_q   <= linha_d;
      coluna_q  <= coluna_d;
      erro_q    <= erro_d;
      byte_q    <= byte_d;
      codigo_q  <= codigo_d;
      db_dado_q <= db_dado_d;
    end
  end

  assign escreve          = (estado_q == ESCREVE);
  assign pronto           = (estado_q == FIM);
  assign addr_linha       = linha_q;
  assign addr_coluna      = coluna_q;
  assign dados_pixel      = codigo_q;
  assign erro             = erro_q;
  assign db_estado        = estado_q;
  assign db_dado_recebido = db_dado_q;

endmodule

// File: tb/tb_recepcao_face_serial.sv
// Scoreboard bench for recepcao_face_serial: expected writes are queued as
// bytes are sent and compared when escreve pulses.
module tb_recepcao_face_serial;

  localparam int BIT = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       entrada_serial = 1'b1;
  logic       escreve;
  logic [1:0] addr_linha;
  logic [1:0] addr_coluna;
  logic [2:0] dados_pixel;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;
  logic [7:0] db_dado_recebido;

  always #5 clock = ~clock;

  recepcao_face_serial #(
    .CLK_FREQ(1000),
    .BAUD    (100),
    .LINHAS  (3),
    .COLUNAS (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar         (iniciar),
    .entrada_serial  (entrada_serial),
    .escreve         (escreve),
    .addr_linha      (addr_linha),
    .addr_coluna     (addr_coluna),
    .dados_pixel     (dados_pixel),
    .pronto          (pronto),
    .erro            (erro),
    .db_estado       (db_estado),
    .db_dado_recebido(db_dado_recebido)
  );

  typedef struct packed {
    logic [1:0] l;
    logic [1:0] c;
    logic [2:0] d;
  } esc_t;

  esc_t fila[$];
  int   checks = 0;
  int   errors = 0;
  int   pos = 0;
  bit   ativo = 1'b0;
  int   n_push = 0;
  int   n_esc = 0;
  logic esc_ant = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cor(input logic [7:0] b);
    case (b)
      8'h57, 8'h77: return 0;
      8'h59, 8'h79: return 1;
      8'h52, 8'h72: return 2;
      8'h4F, 8'h6F: return 3;
      8'h42, 8'h62: return 4;
      8'h47, 8'h67: return 5;
      8'h0D, 8'h0A: return -2;
      default:      return -1;
    endcase
  endfunction

  always @(negedge clock) begin
    esc_t e;
    if (escreve) begin
      n_esc++;
      check("escreve_um_ciclo", 32'(esc_ant), 32'd0);
      if (fila.size() == 0) begin
        check("escreve_inesperado", 32'd1, 32'd0);
      end else begin
        e = fila.pop_front();
        check("addr_linha", 32'(addr_linha), 32'(e.l));
        check("addr_coluna", 32'(addr_coluna), 32'(e.c));
        check("dados_pixel", 32'(dados_pixel), 32'(e.d));
      end
    end
    esc_ant = escreve;
  end

  // Called on a falling edge; returns on the falling edge that ends the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    int c;
    c = cor(b);
    if (ativo && stop && c >= 0) begin
      fila.push_back('{l: 2'(pos / 3), c: 2'(pos % 3), d: 3'(c)});
      pos++;
      n_push++;
      if (pos == 9) ativo = 1'b0;
    end
    entrada_serial = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      entrada_serial = b[i];
      repeat (BIT) @(negedge clock);
    end
    entrada_serial = stop;
    repeat (BIT) @(negedge clock);
    entrada_serial = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic pulso_iniciar();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    pos = 0;
    ativo = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_escreve"}, 32'(escreve), 32'd0);
    check({tag, "_linha"}, 32'(addr_linha), 32'd0);
    check({tag, "_coluna"}, 32'(addr_coluna), 32'd0);
    check({tag, "_dados"}, 32'(dados_pixel), 32'd0);
    check({tag, "_pronto"}, 32'(pronto), 32'd0);
    check({tag, "_erro"}, 32'(erro), 32'd0);
    check({tag, "_estado"}, 32'(db_estado), 32'd0);
    check({tag, "_db_dado"}, 32'(db_dado_recebido), 32'd0);
  endtask

  initial begin
    logic [7:0] parcial;
    parcial = 8'h42;

    // Reset state
    repeat (3) @(negedge clock);
    check_reset_state("rst");
    reset = 1'b1;
    @(negedge clock);
    check("estado_inicial", 32'(db_estado), 32'd0);

    // Full face
    pulso_iniciar();
    check("estado_prepara", 32'(db_estado), 32'd1);
    @(negedge clock);
    check("estado_espera", 32'(db_estado), 32'd2);
    send_str("WYROBGWYR");
    repeat (10) @(negedge clock);
    check("f1_pronto", 32'(pronto), 32'd1);
    check("f1_erro", 32'(erro), 32'd0);
    check("f1_estado", 32'(db_estado), 32'd6);
    check("f1_db_dado", 32'(db_dado_recebido), 32'h52);

    // Restart, then a one-clock glitch while idle
    pulso_iniciar();
    @(negedge clock);
    entrada_serial = 1'b0;
    @(negedge clock);
    entrada_serial = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch_erro", 32'(erro), 32'd0);
    check("glitch_db_dado", 32'(db_dado_recebido), 32'h52);
    check("glitch_estado", 32'(db_estado), 32'd2);

    // Framing error on 'R', then a valid 'R' at the same address
    send_byte(8'h52, 1'b0);
    repeat (20) @(negedge clock);
    check("quadro_erro", 32'(erro), 32'd1);
    check("quadro_coluna", 32'(addr_coluna), 32'd0);
    check("quadro_linha", 32'(addr_linha), 32'd0);
    send_byte(8'h52, 1'b1);
    repeat (10) @(negedge clock);
    check("quadro_avanca", 32'(addr_coluna), 32'd1);

    // Reset in the middle of the 4th data bit
    entrada_serial = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      entrada_serial = parcial[i];
      repeat (BIT) @(negedge clock);
    end
    entrada_serial = parcial[3];
    repeat (BIT / 2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_state("rst_meio");
    entrada_serial = 1'b1;
    ativo = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Face with lowercase, CR/LF and an invalid letter
    pulso_iniciar();
    @(negedge clock);
    send_str("w\r\n");
    repeat (10) @(negedge clock);
    check("crlf_erro", 32'(erro), 32'd0);
    check("crlf_coluna", 32'(addr_coluna), 32'd1);
    send_byte(8'h58, 1'b1);
    repeat (10) @(negedge clock);
    check("x_erro", 32'(erro), 32'd1);
    check("x_coluna", 32'(addr_coluna), 32'd1);
    send_str("yROBGWYR");
    repeat (10) @(negedge clock);
    check("f2_pronto", 32'(pronto), 32'd1);
    check("f2_erro", 32'(erro), 32'd1);

    // Byte while in FIM is ignored; iniciar restarts
    send_byte(8'h47, 1'b1);
    repeat (10) @(negedge clock);
    check("fim_pronto", 32'(pronto), 32'd1);
    check("fim_erro", 32'(erro), 32'd1);
    check("fim_db_dado", 32'(db_dado_recebido), 32'h47);
    check("fim_estado", 32'(db_estado), 32'd6);
    pulso_iniciar();
    check("rein_estado", 32'(db_estado), 32'd1);
    check("rein_pronto", 32'(pronto), 32'd0);
    @(negedge clock);
    check("rein_erro", 32'(erro), 32'd0);
    check("rein_linha", 32'(addr_linha), 32'd0);
    check("rein_coluna", 32'(addr_coluna), 32'd0);
    send_byte(8'h62, 1'b1);
    repeat (10) @(negedge clock);

    check("fila_vazia", 32'(fila.size()), 32'd0);
    check("total_escritas", 32'(n_esc), 32'(n_push));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
